// File: rtl/pm_norm_engine.sv
// pm_norm_engine: path-metric normalisation for the Viterbi ACS feedback.
// Captures one trellis step, scans LANES metrics per cycle for the signed
// maximum (lowest index wins ties), then subtracts it from every active state.
// Build option: define PM_NORM_SAT_EN to clamp the subtraction at the most
// negative metric; by default the subtraction wraps modulo 2^WIDTH_PM.
module pm_norm_engine #(
  parameter int WIDTH_PM    = 8,
  parameter int STATES_LOG2 = 6,
  parameter int LANES       = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_an_i,
  input  logic                                   rst_sync_i,
  input  logic                                   init_i,
  input  logic                                   tail_biting_en_i,
  input  logic [1:0]                             register_num_i,
  input  logic [WIDTH_PM*(1<<STATES_LOG2)-1:0]   pm_tmp_i,
  input  logic                                   pm_valid_i,
  output logic                                   pm_ready_o,
  output logic [WIDTH_PM*(1<<STATES_LOG2)-1:0]   pm_o,
  output logic                                   pm_valid_o,
  output logic [STATES_LOG2-1:0]                 max_state_index_o,
  output logic [WIDTH_PM-1:0]                    max_pm_o
);

  localparam int NS         = 1 << STATES_LOG2;
  localparam int LANES_LOG2 = $clog2(LANES);
  localparam int GROUPS     = NS / LANES;
  localparam int GW         = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  localparam logic [STATES_LOG2:0]         NS_V       = (STATES_LOG2+1)'(NS);
  localparam logic [STATES_LOG2:0]         LANES_V    = (STATES_LOG2+1)'(LANES);
  localparam logic signed [WIDTH_PM-1:0]   PM_MIN     = {1'b1, {(WIDTH_PM-1){1'b0}}};
  localparam logic signed [WIDTH_PM-1:0]   PM_TB_INIT = {2'b11, {(WIDTH_PM-2){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, SUB} state_e;

  state_e                      state_q, state_d;
  logic signed [WIDTH_PM-1:0]  shadow_q [NS];
  logic signed [WIDTH_PM-1:0]  shadow_d [NS];
  logic [STATES_LOG2:0]        na_q, na_d, na_in;
  logic signed [WIDTH_PM-1:0]  run_max_q, run_max_d, scan_max;
  logic [STATES_LOG2-1:0]      run_idx_q, run_idx_d, scan_idx, lane_idx;
  logic [GW-1:0]               grp_q, grp_d, last_grp;
  logic signed [WIDTH_PM-1:0]  pm_q [NS];
  logic signed [WIDTH_PM-1:0]  pm_d [NS];
  logic signed [WIDTH_PM-1:0]  sub_pm [NS];
  logic                        pm_valid_q, pm_valid_d;
  logic [STATES_LOG2-1:0]      max_idx_q, max_idx_d;
  logic signed [WIDTH_PM-1:0]  max_pm_q, max_pm_d;

`ifdef PM_NORM_SAT_EN
  logic signed [WIDTH_PM:0]    diff;
`endif

  // Active state count for the incoming step, never below one state
  always_comb begin
    na_in = NS_V >> register_num_i;
    if (na_in == '0) na_in = (STATES_LOG2+1)'(1);
  end

  // Index of the final scan group for the captured state count
  always_comb begin
    last_grp = '0;
    if (na_q > LANES_V) last_grp = GW'((na_q >> LANES_LOG2) - 1'b1);
  end

  // One group of lanes against the running max; strict compare keeps the lowest index on ties
  always_comb begin
    scan_max = run_max_q;
    scan_idx = run_idx_q;
    lane_idx = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx = STATES_LOG2'((int'(grp_q) << LANES_LOG2) + l);
      if (({1'b0, lane_idx} < na_q) && (shadow_q[lane_idx] > scan_max)) begin
        scan_max = shadow_q[lane_idx];
        scan_idx = lane_idx;
      end
    end
  end

  // Normalised metrics: active states minus the max, inactive states parked at the floor
  always_comb begin
`ifdef PM_NORM_SAT_EN
    diff = '0;
`endif
    for (int k = 0; k < NS; k++) begin
      sub_pm[k] = PM_MIN;
      if ((STATES_LOG2+1)'(k) < na_q) begin
`ifdef PM_NORM_SAT_EN
        diff = {shadow_q[k][WIDTH_PM-1], shadow_q[k]} - {run_max_q[WIDTH_PM-1], run_max_q};
        if (diff[WIDTH_PM] != diff[WIDTH_PM-1]) sub_pm[k] = PM_MIN;
        else                                    sub_pm[k] = diff[WIDTH_PM-1:0];
`else
        sub_pm[k] = shadow_q[k] - run_max_q;
`endif
      end
    end
  end

  // Next state: sync reset, then init, then the IDLE -> SCAN -> SUB sequence
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    na_d       = na_q;
    run_max_d  = run_max_q;
    run_idx_d  = run_idx_q;
    grp_d      = grp_q;
    pm_d       = pm_q;
    pm_valid_d = 1'b0;
    max_idx_d  = max_idx_q;
    max_pm_d   = max_pm_q;
    if (rst_sync_i) begin
      state_d   = IDLE;
      na_d      = '0;
      run_max_d = '0;
      run_idx_d = '0;
      grp_d     = '0;
      max_idx_d = '0;
      max_pm_d  = '0;
      for (int k = 0; k < NS; k++) begin
        shadow_d[k] = '0;
        pm_d[k]     = '0;
      end
    end else if (init_i) begin
      state_d   = IDLE;
      max_idx_d = '0;
      max_pm_d  = '0;
      for (int k = 0; k < NS; k++) begin
        if (tail_biting_en_i || (k == 0)) pm_d[k] = '0;
        else                              pm_d[k] = PM_TB_INIT;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (pm_valid_i) begin
            for (int k = 0; k < NS; k++) shadow_d[k] = pm_tmp_i[k*WIDTH_PM +: WIDTH_PM];
            na_d      = na_in;
            run_max_d = PM_MIN;
            run_idx_d = '0;
            grp_d     = '0;
            state_d   = SCAN;
          end
        end
        SCAN: begin
          run_max_d = scan_max;
          run_idx_d = scan_idx;
          if (grp_q == last_grp) state_d = SUB;
          else                   grp_d   = grp_q + 1'b1;
        end
        SUB: begin
          pm_d       = sub_pm;
          pm_valid_d = 1'b1;
          max_idx_d  = run_idx_q;
          max_pm_d   = run_max_q;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_q    <= IDLE;
      na_q       <= '0;
      run_max_q  <= '0;
      run_idx_q  <= '0;
      grp_q      <= '0;
      pm_valid_q <= 1'b0;
      max_idx_q  <= '0;
      max_pm_q   <= '0;
      for (int k = 0; k < NS; k++) begin
        shadow_q[k] <= '0;
        pm_q[k]     <= '0;
      end
    end else begin
      state_q    <= state_d;
      na_q       <= na_d;
      run_max_q  <= run_max_d;
      run_idx_q  <= run_idx_d;
      grp_q      <= grp_d;
      pm_valid_q <= pm_valid_d;
      max_idx_q  <= max_idx_d;
      max_pm_q   <= max_pm_d;
      shadow_q   <= shadow_d;
      pm_q       <= pm_d;
    end
  end

  // Pack the held metrics onto the output bus
  always_comb begin
    for (int k = 0; k < NS; k++) pm_o[k*WIDTH_PM +: WIDTH_PM] = pm_q[k];
  end

  assign pm_ready_o        = (state_q == IDLE);
  assign pm_valid_o        = pm_valid_q;
  assign max_state_index_o = max_idx_q;
  assign max_pm_o          = max_pm_q;

endmodule

// File: tb/tb_pm_norm_engine.sv
// tb_pm_norm_engine: table vectors, randomized steps against a reference
// model, and hand-written reset / init / back-to-back sequences.
module tb_pm_norm_engine;

  localparam int W   = 8;
  localparam int SL  = 6;
  localparam int NS  = 64;
  localparam int PMW = W * NS;

  logic            clk_i;
  logic            rst_an_i;
  logic            rst_sync_i;
  logic            init_i;
  logic            tail_biting_en_i;
  logic [1:0]      register_num_i;
  logic [PMW-1:0]  pm_tmp_i;
  logic            pm_valid_i;
  logic            pm_ready_o;
  logic [PMW-1:0]  pm_o;
  logic            pm_valid_o;
  logic [SL-1:0]   max_state_index_o;
  logic [W-1:0]    max_pm_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [PMW-1:0] pm_in;
    logic [1:0]     rn;
    int             lat;
    logic [SL-1:0]  idx;
    logic [W-1:0]   mx;
    logic [PMW-1:0] pm_exp;
  } vec_t;

  pm_norm_engine #(.WIDTH_PM(W), .STATES_LOG2(SL), .LANES(8)) dut (
    .clk_i             (clk_i),
    .rst_an_i          (rst_an_i),
    .rst_sync_i        (rst_sync_i),
    .init_i            (init_i),
    .tail_biting_en_i  (tail_biting_en_i),
    .register_num_i    (register_num_i),
    .pm_tmp_i          (pm_tmp_i),
    .pm_valid_i        (pm_valid_i),
    .pm_ready_o        (pm_ready_o),
    .pm_o              (pm_o),
    .pm_valid_o        (pm_valid_o),
    .max_state_index_o (max_state_index_o),
    .max_pm_o          (max_pm_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [PMW-1:0] act, input logic [PMW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Spec-level model: find the first strict maximum among the active states, then subtract
  function automatic void refModel(input logic [PMW-1:0] din, input logic [1:0] rn,
                                   output logic [PMW-1:0] dout, output logic [SL-1:0] idx,
                                   output logic [W-1:0] mx, output int lat);
    int na, best, bi, v, d, c;
    na = NS >> rn;
    if (na < 1) na = 1;
    best = -100000;
    bi = 0;
    for (int k = 0; k < na; k++) begin
      v = int'($signed(din[k*W +: W]));
      if (v > best) begin
        best = v;
        bi = k;
      end
    end
    dout = '0;
    for (int k = 0; k < NS; k++) begin
      if (k < na) begin
        d = int'($signed(din[k*W +: W])) - best;
`ifdef PM_NORM_SAT_EN
        if (d < -128) d = -128;
`endif
        dout[k*W +: W] = d[7:0];
      end else begin
        dout[k*W +: W] = 8'h80;
      end
    end
    idx = SL'(bi);
    mx = best[7:0];
    c = na / 8;
    if (c < 1) c = 1;
    lat = c + 1;
  endfunction

  // Present one step, drop valid after the accept edge and time the pm_valid_o pulse
  task automatic applyStimulus(input logic [PMW-1:0] din, input logic [1:0] rn,
                               output int lat, output int ready_hi);
    int w;
    lat = -1;
    ready_hi = 0;
    w = 0;
    @(negedge clk_i);
    while (!pm_ready_o && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    pm_tmp_i = din;
    register_num_i = rn;
    pm_valid_i = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk_i);
      if (cyc == 1) begin
        pm_valid_i = 1'b0;
        register_num_i = 2'($urandom_range(0, 3));
        pm_tmp_i = {16{32'($urandom)}};
      end
      if (pm_valid_o) begin
        lat = cyc - 1;
        break;
      end
      if (pm_ready_o) ready_hi++;
    end
  endtask

  // Accept a step and return n negedges later with the scan still running
  task automatic startScan(input logic [PMW-1:0] din, input logic [1:0] rn, input int n);
    @(negedge clk_i);
    pm_tmp_i = din;
    register_num_i = rn;
    pm_valid_i = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk_i);
      if (c == 1) pm_valid_i = 1'b0;
    end
  endtask

  task automatic watchNoValid(input int n, output int pulses);
    pulses = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      if (pm_valid_o) pulses++;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, PMW'(pm_ready_o), PMW'(1));
    checkOutput({tag, "_valid"}, PMW'(pm_valid_o), PMW'(0));
    checkOutput({tag, "_pm"}, pm_o, '0);
    checkOutput({tag, "_idx"}, PMW'(max_state_index_o), PMW'(0));
    checkOutput({tag, "_max"}, PMW'(max_pm_o), PMW'(0));
  endtask

  vec_t           vec [5];
  logic [PMW-1:0] din, epm, tailpat;
  logic [SL-1:0]  eidx;
  logic [W-1:0]   emx;
  int             lat, rhi, elat, pulses;
  logic [PMW-1:0] b2b_pm [5];
  logic [SL-1:0]  b2b_idx [5];
  int             acc_cyc [5];
  int             sent, recv, cyc, stray;

  initial begin
    rst_an_i = 1'b0;
    rst_sync_i = 1'b0;
    init_i = 1'b0;
    tail_biting_en_i = 1'b0;
    register_num_i = 2'd0;
    pm_tmp_i = '0;
    pm_valid_i = 1'b0;

    for (int k = 0; k < NS; k++) tailpat[k*W +: W] = (k == 0) ? 8'h00 : 8'hC0;

    // 64-state ramp k-32: max 31 at state 63
    vec[0].rn = 2'd0; vec[0].lat = 9; vec[0].idx = 6'd63; vec[0].mx = 8'd31;
    for (int k = 0; k < NS; k++) begin
      vec[0].pm_in[k*W +: W]  = 8'(k - 32);
      vec[0].pm_exp[k*W +: W] = 8'(k - 63);
    end
    // all-equal metrics: tie goes to state 0
    vec[1].rn = 2'd0; vec[1].lat = 9; vec[1].idx = 6'd0; vec[1].mx = 8'd5;
    for (int k = 0; k < NS; k++) begin
      vec[1].pm_in[k*W +: W]  = 8'd5;
      vec[1].pm_exp[k*W +: W] = 8'd0;
    end
    // 8 states, 100 and -100: overflow of the subtraction
    vec[2].rn = 2'd3; vec[2].lat = 2; vec[2].idx = 6'd0; vec[2].mx = 8'd100;
    vec[2].pm_in = '0;
    vec[2].pm_in[0 +: W] = 8'd100;
    vec[2].pm_in[W +: W] = 8'(-100);
    for (int k = 0; k < NS; k++) vec[2].pm_exp[k*W +: W] = (k < 8) ? 8'(-100) : 8'h80;
    vec[2].pm_exp[0 +: W] = 8'd0;
`ifdef PM_NORM_SAT_EN
    vec[2].pm_exp[W +: W] = 8'h80;
`else
    vec[2].pm_exp[W +: W] = 8'd56;
`endif
    // 32 states, descending, with a large value in a masked state
    vec[3].rn = 2'd1; vec[3].lat = 5; vec[3].idx = 6'd0; vec[3].mx = 8'd40;
    for (int k = 0; k < NS; k++) begin
      vec[3].pm_in[k*W +: W]  = (k < 32) ? 8'(40 - k) : 8'd0;
      vec[3].pm_exp[k*W +: W] = (k < 32) ? 8'(-k) : 8'h80;
    end
    vec[3].pm_in[40*W +: W] = 8'd120;
    // 16 states, negative max -3 tied at 13 and 14
    vec[4].rn = 2'd2; vec[4].lat = 3; vec[4].idx = 6'd13; vec[4].mx = 8'hFD;
    for (int k = 0; k < NS; k++) begin
      vec[4].pm_in[k*W +: W]  = 8'h80;
      vec[4].pm_exp[k*W +: W] = (k < 16) ? 8'h83 : 8'h80;
    end
    vec[4].pm_in[13*W +: W] = 8'hFD;
    vec[4].pm_in[14*W +: W] = 8'hFD;
    vec[4].pm_exp[13*W +: W] = 8'h00;
    vec[4].pm_exp[14*W +: W] = 8'h00;

    repeat (3) @(negedge clk_i);
    rst_an_i = 1'b1;
    @(negedge clk_i);
    checkResetState("reset");

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vec[i].pm_in, vec[i].rn, lat, rhi);
      checkOutput($sformatf("vec%0d_lat", i), PMW'(lat), PMW'(vec[i].lat));
      checkOutput($sformatf("vec%0d_ready_busy", i), PMW'(rhi), PMW'(0));
      checkOutput($sformatf("vec%0d_idx", i), PMW'(max_state_index_o), PMW'(vec[i].idx));
      checkOutput($sformatf("vec%0d_max", i), PMW'(max_pm_o), PMW'(vec[i].mx));
      checkOutput($sformatf("vec%0d_pm", i), pm_o, vec[i].pm_exp);
    end

    $display("[TB] async reset mid-scan");
    startScan(vec[0].pm_in, 2'd0, 3);
    rst_an_i = 1'b0;
    #1;
    checkOutput("arst_async_pm", pm_o, '0);
    @(negedge clk_i);
    rst_an_i = 1'b1;
    @(negedge clk_i);
    checkResetState("arst");
    watchNoValid(12, pulses);
    checkOutput("arst_no_pulse", PMW'(pulses), PMW'(0));

    $display("[TB] randomized steps");
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < NS; k++)
        din[k*W +: W] = (t % 4 == 3) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      refModel(din, 2'($urandom_range(0, 3)), epm, eidx, emx, elat);
      refModel(din, register_num_i, epm, eidx, emx, elat);
      applyStimulus(din, register_num_i, lat, rhi);
      checkOutput($sformatf("rand%0d_lat", t), PMW'(lat), PMW'(elat));
      checkOutput($sformatf("rand%0d_idx", t), PMW'(max_state_index_o), PMW'(eidx));
      checkOutput($sformatf("rand%0d_max", t), PMW'(max_pm_o), PMW'(emx));
      checkOutput($sformatf("rand%0d_pm", t), pm_o, epm);
    end

    $display("[TB] init mid-scan, tail-bit");
    applyStimulus(vec[0].pm_in, 2'd0, lat, rhi);
    startScan(vec[1].pm_in, 2'd0, 3);
    init_i = 1'b1;
    tail_biting_en_i = 1'b0;
    @(negedge clk_i);
    init_i = 1'b0;
    checkOutput("init_tb_pm", pm_o, tailpat);
    checkOutput("init_tb_idx", PMW'(max_state_index_o), PMW'(0));
    checkOutput("init_tb_max", PMW'(max_pm_o), PMW'(0));
    checkOutput("init_tb_ready", PMW'(pm_ready_o), PMW'(1));
    watchNoValid(12, pulses);
    checkOutput("init_tb_no_pulse", PMW'(pulses), PMW'(0));

    $display("[TB] init mid-scan, tail-biting");
    startScan(vec[0].pm_in, 2'd0, 3);
    init_i = 1'b1;
    tail_biting_en_i = 1'b1;
    @(negedge clk_i);
    init_i = 1'b0;
    checkOutput("init_tbit_pm", pm_o, '0);
    watchNoValid(12, pulses);
    checkOutput("init_tbit_no_pulse", PMW'(pulses), PMW'(0));

    $display("[TB] init together with valid");
    @(negedge clk_i);
    pm_tmp_i = vec[0].pm_in;
    register_num_i = 2'd0;
    pm_valid_i = 1'b1;
    init_i = 1'b1;
    tail_biting_en_i = 1'b0;
    @(negedge clk_i);
    pm_valid_i = 1'b0;
    init_i = 1'b0;
    checkOutput("init_valid_ready", PMW'(pm_ready_o), PMW'(1));
    checkOutput("init_valid_pm", pm_o, tailpat);
    watchNoValid(12, pulses);
    checkOutput("init_valid_no_pulse", PMW'(pulses), PMW'(0));

    $display("[TB] sync reset mid-scan");
    applyStimulus(vec[0].pm_in, 2'd0, lat, rhi);
    startScan(vec[1].pm_in, 2'd0, 4);
    rst_sync_i = 1'b1;
    @(negedge clk_i);
    rst_sync_i = 1'b0;
    checkResetState("srst");
    watchNoValid(12, pulses);
    checkOutput("srst_no_pulse", PMW'(pulses), PMW'(0));

    $display("[TB] back-to-back");
    sent = 0; recv = 0; cyc = 0; stray = 0;
    register_num_i = 2'd0;
    while ((recv < 5) && (cyc < 200)) begin
      @(negedge clk_i);
      cyc++;
      if (pm_valid_o) begin
        if (recv < sent) begin
          checkOutput($sformatf("b2b%0d_pm", recv), pm_o, b2b_pm[recv]);
          checkOutput($sformatf("b2b%0d_idx", recv), PMW'(max_state_index_o), PMW'(b2b_idx[recv]));
        end else begin
          stray++;
        end
        recv++;
      end
      if (pm_ready_o && sent < 5) begin
        for (int k = 0; k < NS; k++) din[k*W +: W] = 8'($urandom_range(0, 255));
        refModel(din, 2'd0, b2b_pm[sent], b2b_idx[sent], emx, elat);
        pm_tmp_i = din;
        pm_valid_i = 1'b1;
        acc_cyc[sent] = cyc;
        sent++;
      end else if (pm_ready_o) begin
        pm_valid_i = 1'b0;
      end else begin
        pm_tmp_i = {16{32'($urandom)}};
      end
    end
    pm_valid_i = 1'b0;
    checkOutput("b2b_received", PMW'(recv), PMW'(5));
    checkOutput("b2b_stray", PMW'(stray), PMW'(0));
    for (int i = 1; i < 5; i++)
      checkOutput($sformatf("b2b_period%0d", i), PMW'(acc_cyc[i] - acc_cyc[i-1]), PMW'(10));
    watchNoValid(15, pulses);
    checkOutput("b2b_no_extra", PMW'(pulses), PMW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
